// File: rtl/system_divider.sv
`default_nettype none
// ============================================================================
// Module   : system_divider
// Brief    : Register-loaded 32/16 unsigned restoring divider, one quotient
//            bit per cycle. Optional DIV_ZERO_DETECT_EN short-cuts D==0.
// Revision : 1.0 - initial release
// ============================================================================
module system_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] d_n,
    input  logic [15:0] d_d,
    input  logic        en_n,
    input  logic        en_d,
    input  logic        start,
    output logic [31:0] quotient,
    output logic [15:0] remainder,
    output logic        busy,
    output logic        done,
    output logic        dz
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [4:0]  r_cnt;
    logic [31:0] r_n;
    logic [15:0] r_d;
    logic [15:0] r_rem;
    logic [31:0] r_q;
    logic [31:0] r_quotient;
    logic [15:0] r_remainder;
    logic        r_dz;

    logic        w_accept;
    logic        w_fast_dz;
    logic        w_last;
    logic [16:0] w_t;
    logic        w_ge;
    logic [15:0] w_rem_next;
    logic [31:0] w_q_next;

    assign w_accept = start && (r_state != c_RUN);
    assign w_last   = (r_state == c_RUN) && (r_cnt == 5'd31);

`ifdef DIV_ZERO_DETECT_EN
    assign w_fast_dz = w_accept && (r_d == 16'd0);
`else
    assign w_fast_dz = 1'b0;
`endif

    // Partial remainder stays below D, so the 16-bit subtract yields the exact result.
    assign w_t        = {r_rem, r_q[31]};
    assign w_ge       = (w_t >= {1'b0, r_d});
    assign w_rem_next = w_ge ? (w_t[15:0] - r_d) : w_t[15:0];
    assign w_q_next   = {r_q[30:0], w_ge};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_accept) w_state_next = w_fast_dz ? c_DONE : c_RUN;
            end
            c_RUN: begin
                busy = 1'b1;
                if (w_last) w_state_next = c_DONE;
            end
            c_DONE: begin
                done = 1'b1;
                if (w_accept) w_state_next = w_fast_dz ? c_DONE : c_RUN;
                else          w_state_next = c_IDLE;
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= 5'd0;
            r_n         <= 32'd0;
            r_d         <= 16'd0;
            r_rem       <= 16'd0;
            r_q         <= 32'd0;
            r_quotient  <= 32'd0;
            r_remainder <= 16'd0;
            r_dz        <= 1'b0;
        end else begin
            // Operand loads are locked out while iterating; a same-edge load
            // with start lands after the accepted division has sampled N/D.
            if (r_state != c_RUN) begin
                if (en_n) r_n <= d_n;
                if (en_d) r_d <= d_d;
            end
            if (w_accept) begin
                if (w_fast_dz) begin
                    r_quotient  <= 32'hFFFF_FFFF;
                    r_remainder <= r_n[15:0];
                    r_dz        <= 1'b1;
                end else begin
                    r_rem <= 16'd0;
                    r_q   <= r_n;
                    r_cnt <= 5'd0;
                end
            end else if (r_state == c_RUN) begin
                r_rem <= w_rem_next;
                r_q   <= w_q_next;
                r_cnt <= r_cnt + 5'd1;
                if (w_last) begin
                    r_quotient  <= w_q_next;
                    r_remainder <= w_rem_next;
                    r_dz        <= (r_d == 16'd0);
                end
            end
        end
    end

    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign dz        = r_dz;

endmodule
`default_nettype wire

// File: doc/system_divider.md
# system_divider

Register-loaded sequential unsigned divider: the inverse datapath of the team's 16×16 system multiplier. It takes a 32-bit dividend and a 16-bit divisor through enable-gated operand registers and computes a 32-bit quotient and 16-bit remainder by restoring division, one bit per cycle. Results are held in output registers until the next completed division. It sits beside the multiplier on the same operand-load/enable style bus, so software can recover a factor from a stored product.

## Interface
- No parameters; widths fixed: dividend 32, divisor 16, quotient 32, remainder 16.
- clk  in  1  sole clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- d_n  in  32  dividend data.
- d_d  in  16  divisor data.
- en_n  in  1  load d_n into operand register N.
- en_d  in  1  load d_d into operand register D.
- start  in  1  begin division on current N, D.
- quotient  out  32  registered quotient.
- remainder  out  16  registered remainder.
- busy  out  1  high while iterating (state RUN).
- done  out  1  one-cycle completion pulse (state DONE).
- dz  out  1  registered divide-by-zero flag of last completed division.

## Operation
- States: IDLE, RUN, DONE. Counter cnt 0..31. Working regs: 16-bit partial remainder R, 32-bit shift Q.
- Operand loads: en_n/en_d take effect only when state != RUN; ignored during RUN. Independent of each other.
- start accepted in IDLE or DONE; ignored in RUN. Accept uses N, D values held before that edge (an en_n/en_d on the same edge loads, but does not affect this division).
- On accept: R=0, Q=N, cnt=0, state RUN.
- Each RUN edge: T = {R, Q[31]} (17 bits); if T >= {1'b0, D}: R = T − D, shift-in bit 1; else R = T[15:0], bit 0; Q shifts left with the new bit in Q[0]; cnt+1.
- On the 32nd RUN edge: quotient=Q result, remainder=R result, dz=(D==0), state DONE.
- DONE → IDLE next edge unless start accepted.
- Divisor 0 (natural algorithm result): quotient=32'hFFFF_FFFF, remainder=N[15:0].
- quotient/remainder/dz change only at completion; operand loads or aborted runs never alter them.

## Timing
- Reset: state IDLE, cnt 0, N 0, D 0, R 0, Q 0, quotient 0, remainder 0, busy 0, done 0, dz 0. rst overrides all inputs on the same edge.
- Reset mid-RUN: division aborted, outputs return to 0, no done pulse.
- Latency: start accepted at edge k → busy high after k through k+32; outputs valid and done=1 after edge k+32 for exactly one cycle.
- Back-to-back: start during DONE accepted; done low and busy high after that edge.
- busy and done never high together.

## Configuration
- DIV_ZERO_DETECT_EN defined: on accept with D==0, skip RUN; at edge k, write quotient=32'hFFFF_FFFF, remainder=N[15:0], dz=1, and go to DONE (done after edge k, 1-cycle latency).
- Undefined: no special case; D==0 runs the full 32 cycles with the identical quotient/remainder; dz still registered as (D==0) at completion.
- Result values identical both ways; only latency differs.

## Test plan
- Load N=699678, D=567, start → after 32 cycles quotient=1234, remainder=0, done one cycle, dz=0; N=100000, D=7 → 14285 r 5.
- Boundaries: N=32'hFFFF_FFFF, D=1 → quotient 32'hFFFF_FFFF r 0; N=4294836225, D=65535 → 65535 r 0; N=5, D=1000 → 0 r 5.
- Divide by zero: N=12345, D=0 → quotient 32'hFFFF_FFFF, remainder 12345, dz=1; done 1 cycle after start with DIV_ZERO_DETECT_EN, 32 cycles without it.
- Hold/ignore: during RUN, pulse en_n with 7 and start → result unchanged from the original operands; after done, change d_n/d_d with enables low → outputs hold.
- Same-edge load+start: N=100, load en_n=200 with start → result uses 100; next start uses 200.
- rst high at RUN cycle 10 → busy 0, quotient 0, remainder 0, no done; a subsequent division completes normally.
